// File: rtl/ultrasonic_trig_ctrl.sv
// HC-SR04 initiator: TRIG pulse, ECHO wait/measure, holdoff.
// Optional free-running mode: define AUTO_TRIG_EN.
module ultrasonic_trig_ctrl #(
  parameter int CW            = 20,
  parameter int TRIG_CYCLES   = 120,
  parameter int ECHO_START_TO = 12000,
  parameter int ECHO_MAX      = 456000,
  parameter int HOLDOFF       = 720000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          echo,
  output logic          trig,
  output logic          busy,
  output logic          echo_gate,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] pulse_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(ECHO_START_TO - 1);
  localparam logic [CW-1:0] MEAS_MAX  = CW'(ECHO_MAX);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          echo_m;
  logic          echo_s;
  logic          echo_q;
  logic          rise;
  logic          go;

`ifdef AUTO_TRIG_EN
  assign go = start | 1'b1;
`else
  assign go = start;
`endif

  assign rise = echo_s & ~echo_q;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_q <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_q <= echo_s;
    end
  end

  // Measurement FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      trig         <= 1'b0;
      busy         <= 1'b0;
      echo_gate    <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      pulse_cycles <= '0;
    end else begin
      done      <= 1'b0;
      timeout   <= 1'b0;
      echo_gate <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            state <= S_TRIG;
            cnt   <= '0;
            trig  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_TRIG: begin
          if (cnt == TRIG_LAST) begin
            state <= S_WAIT_RISE;
            cnt   <= '0;
            trig  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_RISE: begin
          if (rise) begin
            state     <= S_MEASURE;
            cnt       <= CW'(1);
            echo_gate <= 1'b1;
          end else if (cnt == WAIT_LAST) begin
            state        <= S_HOLDOFF;
            cnt          <= '0;
            done         <= 1'b1;
            timeout      <= 1'b1;
            pulse_cycles <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          if (!echo_s) begin
            state        <= S_HOLDOFF;
            cnt          <= '0;
            done         <= 1'b1;
            pulse_cycles <= cnt;
          end else if (cnt == MEAS_MAX) begin
            state        <= S_HOLDOFF;
            cnt          <= '0;
            done         <= 1'b1;
            timeout      <= 1'b1;
            pulse_cycles <= MEAS_MAX;
          end else begin
            cnt       <= cnt + 1'b1;
            echo_gate <= 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (cnt == HOLD_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_trig_ctrl.sv
// Directed bench for ultrasonic_trig_ctrl with short sim parameters.
// Done results are captured by a small monitor on each done pulse.
module tb_ultrasonic_trig_ctrl;

  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          echo = 1'b0;
  logic          trig;
  logic          busy;
  logic          echo_gate;
  logic          done;
  logic          timeout;
  logic [CW-1:0] pulse_cycles;

  int n_chk = 0;
  int n_err = 0;
  int ndone = 0;
  int cap_pc = 0;
  int cap_to = 0;

  ultrasonic_trig_ctrl #(
    .CW(CW),
    .TRIG_CYCLES(4),
    .ECHO_START_TO(20),
    .ECHO_MAX(50),
    .HOLDOFF(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .echo(echo),
    .trig(trig),
    .busy(busy),
    .echo_gate(echo_gate),
    .done(done),
    .timeout(timeout),
    .pulse_cycles(pulse_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) begin
      ndone  <= ndone + 1;
      cap_pc <= int'(pulse_cycles);
      cap_to <= int'(timeout);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_trig_low();
    int n = 0;
    while (trig && n < 50) begin
      tick();
      n++;
    end
    chk("trig_fall", int'(trig), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("idle", int'(busy), 0);
  endtask

  task automatic run_pulse(input int width, input int exp_pc,
                           input int exp_to, input string tag);
    int nd;
    nd = ndone;
    pulse_start();
    wait_trig_low();
    repeat (3) tick();
    echo = 1'b1;
    repeat (width) tick();
    echo = 1'b0;
    wait_idle();
    chk({tag, "_ndone"}, ndone - nd, 1);
    chk({tag, "_pc"}, cap_pc, exp_pc);
    chk({tag, "_to"}, cap_to, exp_to);
  endtask

  initial begin
    int n;
    int nd;
    bit seen;

    #2;
    chk("rst_trig", int'(trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gate", int'(echo_gate), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_to", int'(timeout), 0);
    chk("rst_pc", int'(pulse_cycles), 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef AUTO_TRIG_EN
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("auto_done", int'(done), 1);
    chk("auto_to", int'(timeout), 1);
    n = 0;
    while (!trig && n < 50) begin
      tick();
      n++;
    end
    chk("auto_gap", n, 11);
    chk("auto_start", int'(start), 0);
`else
    // 1: nominal 30-cycle echo
    pulse_start();
    n = 0;
    while (trig && n < 50) begin
      n++;
      tick();
    end
    chk("t1_trig_len", n, 4);
    repeat (5) tick();
    echo = 1'b1;
    repeat (15) tick();
    chk("t1_gate", int'(echo_gate), 1);
    chk("t1_busy", int'(busy), 1);
    repeat (15) tick();
    echo = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("t1_latency", n, 3);
    chk("t1_to", int'(timeout), 0);
    chk("t1_pc", int'(pulse_cycles), 30);
    tick();
    chk("t1_done_1cyc", int'(done), 0);
    chk("t1_pc_hold", int'(pulse_cycles), 30);
    n = 1;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("t1_holdoff", n, 10);

    // 2: no echo -> start timeout
    pulse_start();
    n = 0;
    while (trig && n < 50) begin
      n++;
      tick();
    end
    chk("t2_trig_len", n, 4);
    n = 0;
    seen = 1'b0;
    while (!done && n < 60) begin
      tick();
      n++;
      if (trig) seen = 1'b1;
    end
    chk("t2_wait_len", n, 20);
    chk("t2_to", int'(timeout), 1);
    chk("t2_pc", int'(pulse_cycles), 0);
    chk("t2_retrig", int'(seen), 0);
    wait_idle();

    // 3: overrange and boundary widths
    run_pulse(100, 50, 1, "t3_100");
    run_pulse(50, 50, 0, "t3_50");
    run_pulse(51, 50, 1, "t3_51");
    run_pulse(49, 49, 0, "t3_49");

    // 4: echo stuck high through TRIG
    echo = 1'b1;
    repeat (4) tick();
    nd = ndone;
    pulse_start();
    wait_idle();
    echo = 1'b0;
    chk("t4_ndone", ndone - nd, 1);
    chk("t4_to", cap_to, 1);
    chk("t4_pc", cap_pc, 0);
    repeat (3) tick();

    // 5: starts while busy dropped, then start held
    nd = ndone;
    pulse_start();
    tick();
    pulse_start();
    repeat (8) tick();
    pulse_start();
    wait_idle();
    chk("t5_ndone", ndone - nd, 1);
    repeat (5) tick();
    chk("t5_no_queue_busy", int'(busy), 0);
    chk("t5_no_queue_trig", int'(trig), 0);
    nd = ndone;
    start = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("t5_done", int'(done), 1);
    n = 0;
    while (!trig && n < 50) begin
      tick();
      n++;
    end
    chk("t5_gap", n, 11);
    start = 1'b0;
    wait_idle();
    chk("t5_ndone2", ndone - nd, 2);

    // 6: reset mid-MEASURE and mid-TRIG
    run_pulse(7, 7, 0, "t6_pre");
    chk("t6_pc_pre", int'(pulse_cycles), 7);
    pulse_start();
    wait_trig_low();
    repeat (3) tick();
    echo = 1'b1;
    repeat (10) tick();
    chk("t6_gate_pre", int'(echo_gate), 1);
    nd = ndone;
    rst = 1'b1;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_gate", int'(echo_gate), 0);
    chk("t6_trig", int'(trig), 0);
    chk("t6_pc", int'(pulse_cycles), 0);
    tick();
    rst = 1'b0;
    echo = 1'b0;
    repeat (5) tick();
    chk("t6_nodone", ndone - nd, 0);
    chk("t6_idle", int'(busy), 0);
    pulse_start();
    chk("t6_trig_on", int'(trig), 1);
    rst = 1'b1;
    #1;
    chk("t6_trig_async", int'(trig), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
